// File: rtl/mips_dmem_ctrl.sv
// mips_dmem_ctrl: wait-state data-memory controller for the pipelined MIPS core.
// It wraps a DEPTH_WORDS x 32 word array and supports byte/half/word loads and
// stores, with sign or zero extension on sub-word loads. Misaligned, reserved-size
// and out-of-range accesses are rejected with err.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   req          access request, held by the core until ack
//   we           1 = store, 0 = load
//   size         00 byte, 01 half, 10 word, 11 reserved
//   unsigned_ld  zero-extend sub-word loads when 1
//   addr         byte address
//   wdata        right-aligned store data
//   rdata        registered load result (valid with ack, held until next load/error)
//   ack          one-cycle completion pulse
//   err          rejected-access flag, valid with ack
//   stall        combinational hold for the MEM stage: req & (state != RESP)
module mips_dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        stall
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [2:0]  cnt;

    logic        l_we;
    logic [1:0]  l_size;
    logic        l_uns;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic          a_we;
    logic [1:0]    a_size;
    logic          a_uns;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic          a_err;
    logic [AW-1:0] a_idx;
    logic [3:0]    a_be;
    logic [31:0]   a_wword;
    logic [31:0]   a_rword;
    logic [7:0]    a_byte;
    logic [15:0]   a_half;
    logic [31:0]   a_ldval;
    logic          commit;

    // The access being processed: live inputs while IDLE, latched copy afterwards.
    // With zero wait states the commit edge is also the latch edge, so the commit
    // path must see the inputs directly rather than the not-yet-written latches.
    always_comb begin
        if (state == IDLE) begin
            a_we    = we;
            a_size  = size;
            a_uns   = unsigned_ld;
            a_addr  = addr;
            a_wdata = wdata;
        end else begin
            a_we    = l_we;
            a_size  = l_size;
            a_uns   = l_uns;
            a_addr  = l_addr;
            a_wdata = l_wdata;
        end
    end

    // Error detection, lane enables and load extraction for the current access.
    always_comb begin
        a_err = 1'b0;
        case (a_size)
            2'b00:   a_err = 1'b0;
            2'b01:   if (a_addr[0]) a_err = 1'b1;
            2'b10:   if (a_addr[1:0] != 2'b00) a_err = 1'b1;
            default: a_err = 1'b1;
        endcase
        if (|a_addr[31:2+AW]) a_err = 1'b1;

        a_idx   = a_addr[2 +: AW];
        a_be    = '0;
        a_wword = '0;
        case (a_size)
            2'b00: begin
                a_be    = 4'b0001 << a_addr[1:0];
                a_wword = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                a_be    = a_addr[1] ? 4'b1100 : 4'b0011;
                a_wword = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                a_be    = '1;
                a_wword = a_wdata;
            end
            default: begin
                a_be    = '0;
                a_wword = '0;
            end
        endcase

        a_rword = mem[a_idx];
        a_byte  = a_rword[{a_addr[1:0], 3'b000} +: 8];
        a_half  = a_rword[{a_addr[1], 4'b0000} +: 16];
        case (a_size)
            2'b00:   a_ldval = a_uns ? {24'b0, a_byte} : {{24{a_byte[7]}}, a_byte};
            2'b01:   a_ldval = a_uns ? {16'b0, a_half} : {{16{a_half[15]}}, a_half};
            default: a_ldval = a_rword;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) next_state = RESP;
                    else                  next_state = WAIT;
                end
            end
            WAIT:    if (cnt == 3'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign commit = (state != RESP) && (next_state == RESP);

    // State register, wait counter and request latches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            l_we    <= 1'b0;
            l_size  <= '0;
            l_uns   <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                l_we    <= we;
                l_size  <= size;
                l_uns   <= unsigned_ld;
                l_addr  <= addr;
                l_wdata <= wdata;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Load result register: cleared on error, untouched by a good store.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (commit) begin
            if (a_err)      rdata <= '0;
            else if (!a_we) rdata <= a_ldval;
        end
    end

    // Word array: not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (reset && commit && a_we && !a_err) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (a_be[k]) mem[a_idx][8*k +: 8] <= a_wword[8*k +: 8];
            end
        end
    end

    // Outputs.
    always_comb begin
        ack   = (state == RESP);
        err   = (state == RESP) && a_err;
        stall = req && (state != RESP);
    end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Directed bench for mips_dmem_ctrl: a WAIT_STATES=2 instance carries the functional
// vectors; four extra instances (0, 1, 3, 7 wait states) carry the timing sweep.
module tb_mips_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ack, err, stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .stall(stall)
    );

    // Sweep instances: stores of word 0, only timing is observed.
    logic [3:0]  sreq, sack, serr, sstall;
    logic [31:0] srdata [4];
    logic        s_we = 1'b1;
    logic        s_uns = 1'b0;
    logic [1:0]  s_size = 2'b10;
    logic [31:0] s_addr = 32'h0;
    logic [31:0] s_wdata = 32'h0000_0055;

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned WS = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
        mips_dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(WS)) u_dut (
            .clk(clk), .reset(reset), .req(sreq[g]), .we(s_we), .size(s_size),
            .unsigned_ld(s_uns), .addr(s_addr), .wdata(s_wdata),
            .rdata(srdata[g]), .ack(sack[g]), .err(serr[g]), .stall(sstall[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one access on the main instance starting from an IDLE negedge and
    // returns ack latency (cycles after the req cycle), stall cycles, rdata and err.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int stl,
                          output logic [31:0] rd, output logic e);
        we = w; size = sz; unsigned_ld = u; addr = a; wdata = d; req = 1'b1;
        lat = -1; stl = 0; rd = '0; e = 1'b0;
        #1;
        if (stall) stl++;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack) begin
                lat = n; rd = rdata; e = err;
                break;
            end
            if (stall) stl++;
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat, stl;
        logic [31:0] rd;
        logic e;
        access(w, sz, u, a, d, lat, stl, rd, e);
        check({tag, "/latency"}, lat, 32'd3);
        check({tag, "/stall"}, stl, 32'd3);
        check({tag, "/err"}, {31'b0, e}, {31'b0, exp_err});
        check({tag, "/rdata"}, rd, exp_rd);
        check({tag, "/hold"}, rdata, exp_rd);
        check({tag, "/ackpulse"}, {31'b0, ack}, 32'd0);
    endtask

    task automatic sweep(input int i, input int ws);
        int acks, stl, c, dropc;
        int ackc [3];
        acks = 0; stl = 0;
        ackc = '{-1, -1, -1};
        sreq[i] = 1'b1;
        #1;
        for (c = 0; c < 3 * (ws + 2); c++) begin
            if (c > 0) @(negedge clk);
            if (sstall[i]) stl++;
            if (sack[i]) begin
                if (acks < 3) ackc[acks] = c;
                acks++;
            end
        end
        sreq[i] = 1'b0;
        @(negedge clk);
        check($sformatf("sweep%0d/acks", ws), acks, 32'd3);
        check($sformatf("sweep%0d/stall", ws), stl, 3 * (ws + 1));
        check($sformatf("sweep%0d/first", ws), ackc[0], ws + 1);
        check($sformatf("sweep%0d/gap1", ws), ackc[1] - ackc[0], ws + 2);
        check($sformatf("sweep%0d/gap2", ws), ackc[2] - ackc[1], ws + 2);
        if (ws >= 1) begin
            dropc = -1;
            sreq[i] = 1'b1;
            @(negedge clk);
            sreq[i] = 1'b0;
            for (int n = 2; n <= 20; n++) begin
                @(negedge clk);
                if (sack[i]) begin
                    dropc = n;
                    break;
                end
            end
            @(negedge clk);
            check($sformatf("sweep%0d/dropreq", ws), dropc, ws + 1);
        end
    endtask

    initial begin
        int acnt;
        reset = 1'b0; req = 1'b1; we = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
        addr = 32'h10; wdata = 32'h1111_1111; sreq = '0;

        // Reset with a simultaneous request: nothing may be latched.
        @(negedge clk);
        @(negedge clk);
        check("reset/ack", {31'b0, ack}, 32'd0);
        check("reset/err", {31'b0, err}, 32'd0);
        check("reset/rdata", rdata, 32'd0);
        check("reset/stall", {31'b0, stall}, 32'd1);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset/idle_ack", {31'b0, ack}, 32'd0);

        // Word round-trip and byte-lane behaviour.
        run("st_w_10",   1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        run("ld_w_10",   0, 2'b10, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0);
        run("st_b_12",   1, 2'b00, 0, 32'h12, 32'hAAAA_AA80, 32'hDEAD_BEEF, 0);
        run("ld_w_10b",  0, 2'b10, 0, 32'h10, 32'h0,         32'hDE80_BEEF, 0);
        run("ld_bs_12",  0, 2'b00, 0, 32'h12, 32'h0,         32'hFFFF_FF80, 0);
        run("ld_bu_12",  0, 2'b00, 1, 32'h12, 32'h0,         32'h0000_0080, 0);
        run("ld_hs_12",  0, 2'b01, 0, 32'h12, 32'h0,         32'hFFFF_DE80, 0);
        run("ld_hu_10",  0, 2'b01, 1, 32'h10, 32'h0,         32'h0000_BEEF, 0);
        run("ld_bs_13",  0, 2'b00, 0, 32'h13, 32'h0,         32'hFFFF_FFDE, 0);
        run("ld_hs_10",  0, 2'b01, 0, 32'h10, 32'h0,         32'hFFFF_BEEF, 0);

        // Misalignment and reserved size.
        run("ld_h_11",   0, 2'b01, 0, 32'h11, 32'h0,         32'h0000_0000, 1);
        run("st_w_12",   1, 2'b10, 0, 32'h12, 32'h1234_5678, 32'h0000_0000, 1);
        run("ld_w_10c",  0, 2'b10, 0, 32'h10, 32'h0,         32'hDE80_BEEF, 0);
        run("ld_sz3",    0, 2'b11, 0, 32'h10, 32'h0,         32'h0000_0000, 1);

        // Half store lanes, top word, out of range.
        run("st_w_00",   1, 2'b10, 0, 32'h00, 32'h0102_0304, 32'h0000_0000, 0);
        run("st_h_02",   1, 2'b01, 0, 32'h02, 32'hBBBB_5566, 32'h0000_0000, 0);
        run("ld_w_00",   0, 2'b10, 0, 32'h00, 32'h0,         32'h5566_0304, 0);
        run("st_w_fc",   1, 2'b10, 0, 32'hFC, 32'h0BAD_CAFE, 32'h5566_0304, 0);
        run("ld_w_fc",   0, 2'b10, 0, 32'hFC, 32'h0,         32'h0BAD_CAFE, 0);
        run("st_w_100",  1, 2'b10, 0, 32'h100, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run("ld_w_00b",  0, 2'b10, 0, 32'h00, 32'h0,         32'h5566_0304, 0);
        run("ld_w_hi",   0, 2'b10, 0, 32'h8000_0000, 32'h0,  32'h0000_0000, 1);
        run("st_w_20",   1, 2'b10, 0, 32'h20, 32'h1357_9BDF, 32'h0000_0000, 0);

        // Reset asserted in the second WAIT cycle (the commit edge).
        acnt = 0;
        we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h20; wdata = 32'hCAFE_F00D;
        req = 1'b1;
        @(negedge clk);
        if (ack) acnt++;
        @(negedge clk);
        if (ack) acnt++;
        reset = 1'b0; req = 1'b0;
        @(negedge clk);
        if (ack) acnt++;
        check("midrst/rdata", rdata, 32'd0);
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (ack) acnt++;
        end
        check("midrst/noack", acnt, 32'd0);
        run("ld_w_20",   0, 2'b10, 0, 32'h20, 32'h0,         32'h1357_9BDF, 0);

        // Latency sweep.
        sweep(0, 0);
        sweep(1, 1);
        sweep(2, 3);
        sweep(3, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_dmem_ctrl.md
# mips_dmem_ctrl

Parametrised data-memory subsystem for the pipelined MIPS core. It replaces the single-cycle word/byte data memory with a wait-state memory controller, and wraps an internal word array. It supports byte, halfword and word loads and stores, sign or zero extension on loads, and error reporting for misaligned or out-of-range accesses. The pipeline holds its MEM stage on `stall` until the controller acknowledges each access.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words in the array; power of two, 4..4096.
- `WAIT_STATES`, default 2: extra cycles per access, 0..7.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `req` in 1: access request; the core holds it high until `ack`.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (error).
- `unsigned_ld` in 1: 1 = zero-extend byte/half loads, 0 = sign-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata` out 32: registered load result, valid while `ack` = 1.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: asserted together with `ack` when the access was rejected.
- `stall` out 1: combinational, `req` & (state != RESP).

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE, `req` = 1:**
  - Latch `we`, `size`, `unsigned_ld`, `addr` and `wdata`.
  - If `WAIT_STATES` = 0, go to RESP. Otherwise load `cnt` = `WAIT_STATES` - 1 and go to WAIT.
- **WAIT:** if `cnt` = 0, go to RESP; else decrement `cnt`.
- **Commit:** happens on the edge that enters RESP.
  - A store updates only its selected byte lanes.
  - A load registers the extended result into `rdata`.
- **RESP:** `ack` = 1 and `err` = the latched error flag; next state is IDLE unconditionally.
- Inputs are ignored outside IDLE. Dropping `req` in WAIT does not cancel the access.
- Word index is `addr[2 +: log2(DEPTH_WORDS)]`. Byte order is little-endian: byte k occupies bits [8k+7:8k].
- **Store lanes:**
  - Byte writes lane `addr[1:0]` with `wdata[7:0]`.
  - Half writes lanes {`addr[1]`*2+1, `addr[1]`*2} with `wdata[15:0]`.
  - Word writes all four lanes.
- **Load extension:** extract the lane(s), then extend bit 7 (byte) or bit 15 (half) unless `unsigned_ld` = 1. A word load is unmodified.
- **Error conditions:**
  - `size` = 11.
  - Half with `addr[0]` = 1.
  - Word with `addr[1:0]` != 0.
  - `addr[31:2]` >= `DEPTH_WORDS`.
- **On error:** no array write occurs, `rdata` = 0, and `err` = 1 during the `ack` cycle.
- **Load registers:** `rdata` holds its value after RESP until the next load or error commit. A store leaves it unchanged.

## Timing
- **Reset:**
  - Reset is sampled only on the rising edge and has priority over everything else.
  - Outputs: state IDLE, `cnt` 0, `ack` 0, `err` 0, `rdata` 0.
  - `stall` = `req` while in reset-state IDLE.
  - Array contents are not reset.
- **Latency:** `ack` is high exactly `WAIT_STATES` + 1 cycles after the cycle in which `req` is first sampled high in IDLE.
- **Stall:** `stall` is high for `WAIT_STATES` + 1 cycles per access.
- **Throughput:** one access per `WAIT_STATES` + 2 cycles. After RESP, a `req` still high in IDLE starts a new access.
- **Reset mid-operation:**
  - `reset` low in IDLE or WAIT returns the FSM to IDLE; no commit, no `ack`.
  - `reset` low on the commit edge blocks the write.
- **Simultaneous `req` and reset:** reset wins; the request is not latched.

## Test plan
1. **Reset then word round-trip** (`WAIT_STATES` = 2):
   - Hold reset low for 2 cycles -> `ack`/`err`/`rdata` all 0.
   - Word store 0xDEADBEEF @0x10 -> `ack` 3 cycles after `req`, `err` 0.
   - Word load @0x10 -> `rdata` 0xDEADBEEF.
2. **Byte lanes and extension:**
   - Byte store 0x80 @0x12; word load @0x10 -> 0xDE80BEEF.
   - Signed byte load @0x12 -> 0xFFFFFF80.
   - Unsigned byte load @0x12 -> 0x00000080.
   - Signed half load @0x12 -> 0xFFFFDE80.
3. **Misalignment and reserved size:**
   - Half load @0x11 -> `err` 1, `rdata` 0.
   - Word store 0x12345678 @0x12 -> `err` 1; word @0x10 still 0xDE80BEEF.
   - `size` = 11 -> `err` 1.
4. **Out of range** (`DEPTH_WORDS` = 64):
   - Word store 0xFFFFFFFF @0x100 -> `err` 1 with `ack`.
   - Word load @0x0 unchanged.
5. **Reset mid-operation:**
   - Word store 0xCAFEF00D @0x20 with `reset` low in the second WAIT cycle -> no `ack`.
   - Word load @0x20 returns its prior value; FSM returns to IDLE.
6. **Latency sweep:** for `WAIT_STATES` in {0, 1, 3, 7}, back-to-back requests -> `stall` high `WAIT_STATES` + 1 cycles and `ack` every `WAIT_STATES` + 2 cycles; dropping `req` in WAIT still yields `ack`.
